// File: rtl/muldiv_iter_16_pkg.sv
// Shared types and constants for the iterative 16-bit multiply/divide unit.
// Op encodings, FSM states and the captured-request payload live here.
package muldiv_iter_16_pkg;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned ITERS  = WIDTH;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned ACC_W  = 2 * WIDTH;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned OP_W   = 2;

    localparam logic [OP_W-1:0] OP_MUL  = 2'b00;
    localparam logic [OP_W-1:0] OP_MULH = 2'b01;
    localparam logic [OP_W-1:0] OP_DIVU = 2'b10;
    localparam logic [OP_W-1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Request captured at start; opnd is A for multiply, B for divide.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [WIDTH-1:0]  opnd;
        logic [ADDR_W-1:0] dst;
    } req_t;

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    // Upper half holds the MULH product / remainder, lower half the MUL product / quotient.
    function automatic logic [WIDTH-1:0] result_sel(input logic [OP_W-1:0] op,
                                                    input logic [ACC_W-1:0] acc);
        if ((op == OP_MULH) || (op == OP_REMU)) begin
            return acc[ACC_W-1:WIDTH];
        end
        return acc[WIDTH-1:0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
// Multiply uses acc = {hi, lo}; divide uses acc = {rem[15:0], quo}.
module muldiv_step
    import muldiv_iter_16_pkg::*;
(
    input  logic             div,
    input  logic [ACC_W-1:0] acc,
    input  logic [WIDTH-1:0] opnd,
    output logic [ACC_W-1:0] acc_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_s;
    logic [WIDTH-1:0] quo_s;

    always_comb begin
        acc_next = '0;
        sum      = '0;
        rem_s    = '0;
        quo_s    = '0;
        if (div) begin
            // 17-bit partial remainder after shifting the next dividend bit in.
            rem_s = {acc[ACC_W-1:WIDTH], acc[WIDTH-1]};
            quo_s = {acc[WIDTH-2:0], 1'b0};
            if (rem_s >= {1'b0, opnd}) begin
                acc_next = {WIDTH'(rem_s - {1'b0, opnd}), quo_s | WIDTH'(1)};
            end else begin
                acc_next = {rem_s[WIDTH-1:0], quo_s};
            end
        end else begin
            sum      = {1'b0, acc[ACC_W-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_iter_16.sv
// Iterative 16-bit MUL/MULH/DIVU/REMU unit with start/busy/done handshake.
// Fixed latency: 16 iteration edges after the accepting edge, then one done/load cycle.
module muldiv_iter_16
    import muldiv_iter_16_pkg::*;
(
    input  logic              clk,
    input  logic              nClear,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic [ADDR_W-1:0] dst,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  C,
    output logic [ADDR_W-1:0] Caddr,
    output logic              load
);

    state_t            state;
    state_t            state_next;
    req_t              req_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_step;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;
    logic              last;
    logic              busy_d;
    logic              done_d;
    logic [WIDTH-1:0]  c_d;
    logic [ADDR_W-1:0] caddr_d;

    assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last   = (state == ST_RUN) && (cnt_q == CNT_W'(ITERS - 1));
    assign load   = done;

    muldiv_step u_step (
        .div      (is_div(req_q.op)),
        .acc      (acc_q),
        .opnd     (req_q.opnd),
        .acc_next (acc_step)
    );

    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last)  state_next = ST_DONE;
            ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; C/Caddr hold outside completion.
    always_comb begin
        busy_d  = (state_next == ST_RUN);
        done_d  = last;
        c_d     = C;
        caddr_d = Caddr;
        if (last) begin
            c_d     = result_sel(req_q.op, acc_step);
            caddr_d = req_q.dst;
        end
    end

    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            C     <= '0;
            Caddr <= '0;
        end else begin
            busy  <= busy_d;
            done  <= done_d;
            C     <= c_d;
            Caddr <= caddr_d;
        end
    end

    // Capture on accept; operands are never re-sampled while iterating.
    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            req_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            req_q.op   <= op;
            req_q.dst  <= dst;
            req_q.opnd <= is_div(op) ? B : A;
            acc_q      <= {WIDTH'(0), (is_div(op) ? A : B)};
            cnt_q      <= '0;
        end else if (state == ST_RUN) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_muldiv_iter_16.sv
// Self-checking bench for muldiv_iter_16: directed cases, handshake corners,
// mid-operation reset and random operations against an arithmetic reference.
module tb_muldiv_iter_16;

    logic        clk;
    logic        nClear;
    logic        start;
    logic [1:0]  op;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  dst;
    logic        busy;
    logic        done;
    logic [15:0] C;
    logic [3:0]  Caddr;
    logic        load;

    int checks = 0;
    int errors = 0;

    muldiv_iter_16 dut (
        .clk    (clk),
        .nClear (nClear),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .dst    (dst),
        .busy   (busy),
        .done   (done),
        .C      (C),
        .Caddr  (Caddr),
        .load   (load)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] model(input logic [1:0] o, input logic [15:0] a,
                                          input logic [15:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        case (o)
            2'b00:   return p[15:0];
            2'b01:   return p[31:16];
            2'b10:   return (b == 16'd0) ? 16'hFFFF : a / b;
            default: return (b == 16'd0) ? a : a % b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one request so that it is sampled at the next rising edge (edge N).
    task automatic launch(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] d);
        @(negedge clk);
        op = o; A = a; B = b; dst = d; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges after edge N until done; optionally pulse start with junk operands.
    task automatic wait_done(input int pulse_at, output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (pulse_at != 0 && k == pulse_at) begin
                start = 1'b1; A = 16'hAAAA; B = 16'h5555; dst = 4'd9; op = 2'b01;
            end
            if (pulse_at != 0 && k == pulse_at + 1) start = 1'b0;
            if (k == 8) chk("busy_mid_run", 32'(busy), 32'd1);
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] d, input logic [15:0] exp);
        int lat;
        launch(o, a, b, d);
        wait_done(0, lat);
        chk({tag, "_latency"}, 32'(lat), 32'd16);
        chk({tag, "_C"}, 32'(C), 32'(exp));
        chk({tag, "_Caddr"}, 32'(Caddr), 32'(d));
        chk({tag, "_load"}, 32'(load), 32'd1);
        @(posedge clk);
        #1;
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, "_C_hold"}, 32'(C), 32'(exp));
    endtask

    initial begin
        int lat;
        int lat2;
        int loads;
        logic [1:0]  ro;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [3:0]  rd;

        nClear = 1'b0; start = 1'b0; op = 2'b00; A = 16'h1234; B = 16'h0010; dst = 4'd3;

        // Reset held: start toggling must have no effect.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = ~start;
        end
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_C", 32'(C), 32'h0000);
        chk("rst_Caddr", 32'(Caddr), 32'd0);
        @(negedge clk);
        start = 1'b0;
        nClear = 1'b1;
        repeat (2) @(posedge clk);

        run_op("mul_1234", 2'b00, 16'h1234, 16'h0010, 4'd3, 16'h2340);
        run_op("mulh_1234", 2'b01, 16'h1234, 16'h0010, 4'd3, 16'h0001);
        run_op("mul_ffff", 2'b00, 16'hFFFF, 16'hFFFF, 4'd5, 16'h0001);
        run_op("mulh_ffff", 2'b01, 16'hFFFF, 16'hFFFF, 4'd6, 16'hFFFE);
        run_op("divu_100_7", 2'b10, 16'd100, 16'd7, 4'd7, 16'h000E);
        run_op("remu_100_7", 2'b11, 16'd100, 16'd7, 4'd8, 16'h0002);
        run_op("divu_ffff_1", 2'b10, 16'hFFFF, 16'd1, 4'd10, 16'hFFFF);
        run_op("remu_ffff_1", 2'b11, 16'hFFFF, 16'd1, 4'd11, 16'h0000);
        run_op("divu_by0", 2'b10, 16'h1234, 16'd0, 4'd12, 16'hFFFF);
        run_op("remu_by0", 2'b11, 16'h1234, 16'd0, 4'd13, 16'h1234);

        // Start pulsed during RUN with different operands must be ignored.
        launch(2'b00, 16'h1234, 16'h0010, 4'd3);
        wait_done(5, lat);
        chk("ignore_latency", 32'(lat), 32'd16);
        chk("ignore_C", 32'(C), 32'h2340);
        chk("ignore_Caddr", 32'(Caddr), 32'd3);
        @(posedge clk);
        #1;
        chk("ignore_no_second", 32'(busy), 32'd0);

        // Back-to-back: start in the DONE cycle; second load lands 17 cycles after the first.
        launch(2'b10, 16'd100, 16'd7, 4'd1);
        wait_done(0, lat);
        chk("b2b_first_latency", 32'(lat), 32'd16);
        chk("b2b_first_C", 32'(C), 32'h000E);
        launch(2'b11, 16'd100, 16'd7, 4'd2);
        chk("b2b_done_dropped", 32'(done), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done(0, lat2);
        chk("b2b_gap", 32'(lat2 + 1), 32'd17);
        chk("b2b_second_C", 32'(C), 32'h0002);
        chk("b2b_second_Caddr", 32'(Caddr), 32'd2);
        @(posedge clk);
        #1;

        // Asynchronous reset after iteration 8 of a MUL aborts without any load.
        launch(2'b00, 16'h00FF, 16'h00FF, 4'd4);
        repeat (8) @(posedge clk);
        #2;
        nClear = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_C", 32'(C), 32'h0000);
        chk("abort_Caddr", 32'(Caddr), 32'd0);
        @(negedge clk);
        nClear = 1'b1;
        loads = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (load) loads++;
        end
        chk("abort_no_load", 32'(loads), 32'd0);
        run_op("mul_3_5", 2'b00, 16'd3, 16'd5, 4'd2, 16'h000F);

        // Random operations against the arithmetic reference.
        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) rb = 16'd0;
            else if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(1, 31));
            rd = 4'($urandom);
            run_op($sformatf("rand%0d_op%0d_%h_%h", i, ro, ra, rb), ro, ra, rb, rd,
                   model(ro, ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
